// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU operations,
// FSM states and the decoded-control bundle.
package multicycle_control_unit_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } stateT;

    typedef struct packed {
        logic       regSource;
        logic [2:0] aluOp;
        logic       isMem;
        logic       isLoad;
        logic       isStore;
        logic       writesReg;
    } decodeT;

endpackage

// File: rtl/multicycle_control_unit_cu_decoder.sv
// Combinational opcode decoder: maps the latched opcode to the datapath
// controls and the instruction-class flags that steer the FSM.
module cu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [3:0] opCode,
    output decodeT     dec
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        dec       = '0;
        dec.aluOp = ALU_ADD;
        case (opCode)
            OP_ADD:   begin dec.aluOp = ALU_ADD; dec.writesReg = 1'b1; end
            OP_SUB:   begin dec.aluOp = ALU_SUB; dec.writesReg = 1'b1; end
            OP_AND:   begin dec.aluOp = ALU_AND; dec.writesReg = 1'b1; end
            OP_OR:    begin dec.aluOp = ALU_OR;  dec.writesReg = 1'b1; end
            OP_LOAD: begin
                dec.isMem     = 1'b1;
                dec.isLoad    = 1'b1;
                dec.writesReg = 1'b1;
                dec.regSource = 1'b1;
            end
            OP_STORE: begin
                dec.isMem   = 1'b1;
                dec.isStore = 1'b1;
            end
            default: ; // NOP: no strobes, address-add ALU op
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multi-cycle processor: one state per stage,
// registered stage enables and memory/register strobes.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opCode,
    output logic       enIF,
    output logic       enID,
    output logic       enEX,
    output logic       enMEM,
    output logic       enWB,
    output logic       RegSource,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [2:0] ALUOp
);

    stateT      state;
    logic [3:0] opLatched;
    decodeT     dec;

    cu_decoder uDecoder (
        .opCode (opLatched),
        .dec    (dec)
    );

    // Data controls follow the latched opcode and are held in every state.
    assign RegSource = dec.regSource;
    assign ALUOp     = dec.aluOp;

    // Outputs are registered alongside the state so they describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IF;
            opLatched <= OP_ADD;
            enIF      <= 1'b1;
            enID      <= 1'b0;
            enEX      <= 1'b0;
            enMEM     <= 1'b0;
            enWB      <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            RegWrite  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by the later assignment in the case.
            enIF     <= 1'b0;
            enID     <= 1'b0;
            enEX     <= 1'b0;
            enMEM    <= 1'b0;
            enWB     <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            RegWrite <= 1'b0;
            case (state)
                S_IF: begin
                    state <= S_ID;
                    enID  <= 1'b1;
                end
                S_ID: begin
                    state     <= S_EX;
                    enEX      <= 1'b1;
                    opLatched <= opCode;
                end
                S_EX: begin
                    if (dec.isMem) begin
                        state    <= S_MEM;
                        enMEM    <= 1'b1;
                        MemRead  <= dec.isLoad;
                        MemWrite <= dec.isStore;
                    end else if (dec.writesReg) begin
                        state    <= S_WB;
                        enWB     <= 1'b1;
                        RegWrite <= 1'b1;
                    end else begin
                        state <= S_IF;
                        enIF  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dec.isLoad) begin
                        state    <= S_WB;
                        enWB     <= 1'b1;
                        RegWrite <= 1'b1;
                    end else begin
                        state <= S_IF;
                        enIF  <= 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_IF;
                    enIF  <= 1'b1;
                end
                default: begin
                    state <= S_IF;
                    enIF  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-scenario tasks compared
// against a phase-list reference model derived from the instruction classes.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opCode;
    logic       enIF, enID, enEX, enMEM, enWB;
    logic       RegSource, MemRead, MemWrite, RegWrite;
    logic [2:0] ALUOp;
    logic [4:0] en;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opCode    (opCode),
        .enIF      (enIF),
        .enID      (enID),
        .enEX      (enEX),
        .enMEM     (enMEM),
        .enWB      (enWB),
        .RegSource (RegSource),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ALUOp     (ALUOp)
    );

    assign en = {enWB, enMEM, enEX, enID, enIF};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Phase numbering in the model: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB.
    // Entered at a falling edge with the DUT in IF; leaves it at the next IF.
    task automatic runInstr(input logic [3:0] op, input logic [3:0] opLate, input string tag);
        int         phases[$];
        int         ph;
        logic [4:0] expEn;
        logic [2:0] expAlu;
        logic       expSrc, expRead, expWrite, expReg;
        phases = {0, 1, 2};
        if (op <= 4'd3) phases.push_back(4);
        else if (op == 4'd5) begin phases.push_back(3); phases.push_back(4); end
        else if (op == 4'd6) phases.push_back(3);
        expAlu = (op <= 4'd3) ? op[2:0] : 3'b000;
        expSrc = (op == 4'd5);
        foreach (phases[k]) begin
            ph       = phases[k];
            opCode   = (k <= 1) ? op : opLate;
            expEn    = 5'b00001 << ph;
            expRead  = (ph == 3) && (op == 4'd5);
            expWrite = (ph == 3) && (op == 4'd6);
            expReg   = (ph == 4);
            checks++;
            if (en !== expEn) begin
                failures++;
                $display("FAIL %s enables op=%h phase=%0d got=%b exp=%b", tag, op, ph, en, expEn);
            end
            checks++;
            if ($countones(en) != 1) begin
                failures++;
                $display("FAIL %s onehot op=%h phase=%0d got=%b exp=one bit", tag, op, ph, en);
            end
            checks++;
            if ({MemRead, MemWrite, RegWrite} !== {expRead, expWrite, expReg}) begin
                failures++;
                $display("FAIL %s strobes op=%h phase=%0d got=%b exp=%b", tag, op, ph,
                         {MemRead, MemWrite, RegWrite}, {expRead, expWrite, expReg});
            end
            if (k >= 2) begin
                checks++;
                if ({RegSource, ALUOp} !== {expSrc, expAlu}) begin
                    failures++;
                    $display("FAIL %s datactl op=%h phase=%0d got=%b exp=%b", tag, op, ph,
                             {RegSource, ALUOp}, {expSrc, expAlu});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (en !== 5'b00001) begin
            failures++;
            $display("FAIL %s return_to_if op=%h got=%b exp=00001", tag, op, en);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        opCode = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({en, RegSource, MemRead, MemWrite, RegWrite, ALUOp} !== {5'b00001, 4'b0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b",
                     {en, RegSource, MemRead, MemWrite, RegWrite, ALUOp}, {5'b00001, 7'b0});
        end
        runInstr(4'hF, 4'hF, "reset_walk");
    endtask

    task automatic test_alu();
        for (int i = 0; i < 4; i++) runInstr(4'(i), 4'($urandom_range(15)), "alu");
    endtask

    task automatic test_load();
        runInstr(4'h5, 4'h5, "load");
    endtask

    task automatic test_store();
        runInstr(4'h6, 4'h6, "store");
    endtask

    task automatic test_opcode_change();
        runInstr(4'h5, 4'h0, "opcode_change");
        runInstr(4'h0, 4'h5, "opcode_change_rev");
    endtask

    task automatic test_nop();
        runInstr(4'hF, 4'hF, "nop_f");
        runInstr(4'h4, 4'h5, "nop_4");
        runInstr(4'h7, 4'h6, "nop_7");
    endtask

    task automatic test_reset_mid();
        opCode = 4'h5;
        repeat (3) @(negedge clk);
        checks++;
        if ({enMEM, MemRead} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b exp=11", {enMEM, MemRead});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({en, RegSource, MemRead, MemWrite, RegWrite, ALUOp} !== {5'b00001, 4'b0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid_post got=%b exp=%b",
                     {en, RegSource, MemRead, MemWrite, RegWrite, ALUOp}, {5'b00001, 7'b0});
        end
        runInstr(4'hF, 4'h5, "reset_mid_after");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(15));
            runInstr(op, 4'($urandom_range(15)), "random");
        end
    endtask

    task automatic test_back_to_back();
        runInstr(4'h5, 4'h6, "b2b_load");
        runInstr(4'h6, 4'h5, "b2b_store");
        runInstr(4'h1, 4'hF, "b2b_sub");
        runInstr(4'h3, 4'h2, "b2b_or");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_opcode_change();
        test_nop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
